// File: rtl/obsidian_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// obsidian_dmem_arbiter
//
// Purpose:
//   Sequencing controller and two-way arbiter for the single-port,
//   fixed-latency data memory behind the MEM stage. The pipeline MEM stage
//   and a loader/debug port share the memory. An access is one mem_en strobe
//   followed by MEM_LAT cycles of waiting. The requester that owns the
//   access then gets a one-cycle done pulse and, for reads, a registered
//   copy of the data. When both requesters want the memory in the same
//   idle cycle, they take turns (round-robin).
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   pipe_rd / pipe_wr          MEM-stage load / store request (read wins)
//   pipe_addr, pipe_wdata      MEM-stage word address and store data
//   pipe_rdata, pipe_done      registered load data, completion pulse
//   pipe_stall                 combinational pipeline hold
//   ldr_req, ldr_we            loader request and direction (1 = write)
//   ldr_addr, ldr_wdata        loader word address and write data
//   ldr_rdata, ldr_done        registered loader read data, completion pulse
//   mem_en, mem_we             one-cycle access strobe, write enable
//   mem_addr, mem_wdata        memory address and write data (held per access)
//   mem_rdata                  memory read data, sampled MEM_LAT edges after
//                              the strobe edge
// ---------------------------------------------------------------------------
module obsidian_dmem_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_rd,
   input  logic              pipe_wr,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_wdata,
   output logic [DATA_W-1:0] pipe_rdata,
   output logic              pipe_done,
   output logic              pipe_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // The counter holds MEM_LAT-1 at most. A one-bit counter is kept even for
   // MEM_LAT = 1, so the vector width never collapses to zero.
   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   typedef enum logic { IDLE, ACCESS } arbState_e;
   typedef enum logic { OWN_PIPE, OWN_LDR } owner_e;

   arbState_e         state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            lastOwner_q, lastOwner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              memEn_q, memEn_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [DATA_W-1:0] pipeRdata_q, pipeRdata_d;
   logic [DATA_W-1:0] ldrRdata_q, ldrRdata_d;
   logic              pipeDone_q, pipeDone_d;
   logic              ldrDone_q, ldrDone_d;

   logic              pipeElig;
   logic              ldrElig;
   logic              grantPipe;

   // A requester is masked in the cycle that carries its own done pulse.
   // The request lines are still high in that cycle because the requester
   // has not yet seen its release. Without the mask, the requester would be
   // granted a second, duplicate access.
   assign pipeElig = (pipe_rd | pipe_wr) & ~pipeDone_q;
   assign ldrElig  = ldr_req & ~ldrDone_q;

   // The pipeline is held for as long as it has a memory operation that has
   // not been released by its done pulse, whether waiting or in flight.
   assign pipe_stall = (pipe_rd | pipe_wr) & ~pipeDone_q;

   assign pipe_rdata = pipeRdata_q;
   assign pipe_done  = pipeDone_q;
   assign ldr_rdata  = ldrRdata_q;
   assign ldr_done   = ldrDone_q;
   assign mem_en     = memEn_q;
   assign mem_we     = memWe_q;
   assign mem_addr   = memAddr_q;
   assign mem_wdata  = memWdata_q;

   // State register. On reset, the loader is recorded as the last owner so
   // that the pipeline wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_PIPE;
         lastOwner_q <= OWN_LDR;
         cnt_q       <= '0;
         memEn_q     <= 1'b0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         pipeRdata_q <= '0;
         ldrRdata_q  <= '0;
         pipeDone_q  <= 1'b0;
         ldrDone_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lastOwner_q <= lastOwner_d;
         cnt_q       <= cnt_d;
         memEn_q     <= memEn_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
         pipeRdata_q <= pipeRdata_d;
         ldrRdata_q  <= ldrRdata_d;
         pipeDone_q  <= pipeDone_d;
         ldrDone_q   <= ldrDone_d;
      end
   end

   // Next-state logic.
   // IDLE grants an eligible requester. On a tie, the requester that did not
   // own the previous access wins. ACCESS drops the strobe after one cycle
   // and counts down the latency. On the last edge it captures the read data
   // for the owner and returns to IDLE with the owner's done pulse set. The
   // done cycle is itself an IDLE cycle, so the other requester can be
   // granted in that cycle without a bubble.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lastOwner_d = lastOwner_q;
      cnt_d       = cnt_q;
      memEn_d     = memEn_q;
      memWe_d     = memWe_q;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;
      pipeRdata_d = pipeRdata_q;
      ldrRdata_d  = ldrRdata_q;
      pipeDone_d  = 1'b0;
      ldrDone_d   = 1'b0;
      grantPipe   = pipeElig & (~ldrElig | (lastOwner_q == OWN_LDR));

      case (state_q)
         IDLE: begin
            if (pipeElig | ldrElig) begin
               if (grantPipe) begin
                  owner_d     = OWN_PIPE;
                  lastOwner_d = OWN_PIPE;
                  memAddr_d   = pipe_addr;
                  memWe_d     = pipe_wr & ~pipe_rd;
                  memWdata_d  = pipe_wdata;
               end else begin
                  owner_d     = OWN_LDR;
                  lastOwner_d = OWN_LDR;
                  memAddr_d   = ldr_addr;
                  memWe_d     = ldr_we;
                  memWdata_d  = ldr_wdata;
               end
               memEn_d = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            memEn_d = 1'b0;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (owner_q == OWN_PIPE) begin
                  pipeDone_d = 1'b1;
                  if (!memWe_q) begin
                     pipeRdata_d = mem_rdata;
                  end
               end else begin
                  ldrDone_d = 1'b1;
                  if (!memWe_q) begin
                     ldrRdata_d = mem_rdata;
                  end
               end
               memWe_d = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_obsidian_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_obsidian_dmem_arbiter
//
// Purpose:
//   Directed self-checking bench for obsidian_dmem_arbiter. Instance dut
//   uses MEM_LAT = 2 and is checked on every cycle against a
//   transaction-level model. Instance dut1 uses MEM_LAT = 1 for the
//   short-latency read. Memory models present read data only in the cycle
//   that feeds the capturing edge, so a mistimed capture picks up junk.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_obsidian_dmem_arbiter;

   localparam int          LAT  = 2;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic        pipe_rd, pipe_wr, pipe_done, pipe_stall;
   logic [9:0]  pipe_addr;
   logic [31:0] pipe_wdata, pipe_rdata;
   logic        ldr_req, ldr_we, ldr_done;
   logic [9:0]  ldr_addr;
   logic [31:0] ldr_wdata, ldr_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        pipeRd1, pipeWr1, pipeDone1, pipeStall1;
   logic [9:0]  pipeAddr1;
   logic [31:0] pipeWdata1, pipeRdata1;
   logic        ldrReq1, ldrWe1, ldrDone1;
   logic [9:0]  ldrAddr1;
   logic [31:0] ldrWdata1, ldrRdata1;
   logic        memEn1, memWe1;
   logic [9:0]  memAddr1;
   logic [31:0] memWdata1, memRdata1;

   int checks = 0;
   int errors = 0;

   logic [31:0] envMem [0:1023];
   logic [31:0] golden [0:1023];
   int          memAge;

   int          memEnCnt = 0, pipeDoneCnt = 0, ldrDoneCnt = 0, stallCnt = 0, negCnt = 0;
   logic [9:0]  lastStrobeAddr = '0;
   logic        lastStrobeWe = 1'b0;
   int          doneOwner[$];
   int          doneTime[$];

   logic        expPipeDone = 0, expLdrDone = 0, expMemEn = 0, expMemWe = 0;
   logic [9:0]  expMemAddr = '0;
   logic [31:0] expMemWdata = '0, expPipeRdata = '0, expLdrRdata = '0;

   always #5 clk = ~clk;

   obsidian_dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
      .pipe_rdata(pipe_rdata), .pipe_done(pipe_done), .pipe_stall(pipe_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_done(ldr_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   obsidian_dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .pipe_rd(pipeRd1), .pipe_wr(pipeWr1), .pipe_addr(pipeAddr1), .pipe_wdata(pipeWdata1),
      .pipe_rdata(pipeRdata1), .pipe_done(pipeDone1), .pipe_stall(pipeStall1),
      .ldr_req(ldrReq1), .ldr_we(ldrWe1), .ldr_addr(ldrAddr1), .ldr_wdata(ldrWdata1),
      .ldr_rdata(ldrRdata1), .ldr_done(ldrDone1),
      .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
      .mem_rdata(memRdata1)
   );

   function automatic logic [31:0] initWord(input int i);
      if (i == 3) return 32'h8765_4321;
      return 32'hC0DE_0000 + 32'(i) * 32'd7;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Memory behind dut: writes land on the strobe edge, and read data is
   // valid only in the cycle feeding the MEM_LAT-th edge after the strobe.
   initial begin
      for (int i = 0; i < 1024; i++) envMem[i] = initWord(i);
      memAge = 0;
      forever begin
         @(posedge clk);
         if (mem_en) begin
            memAge <= 1;
            if (mem_we) envMem[mem_addr] <= mem_wdata;
         end else if (memAge != 0 && memAge < 1000) begin
            memAge <= memAge + 1;
         end
      end
   end

   always_comb mem_rdata = (memAge == LAT - 1) ? envMem[mem_addr] : JUNK;

   // With a one-cycle latency, the data must be present in the strobe cycle itself.
   always_comb memRdata1 = memEn1 ? initWord(int'(memAddr1)) : JUNK;

   // Transaction model: an access granted at edge number g finishes at edge
   // g+LAT. Requesters are masked during their done cycle, and ties alternate.
   initial begin
      int   mCyc, mDoneAt;
      logic mBusy, mLastLdr, mOwnerLdr, mIsWrite, pWants, lWants;
      logic [9:0] mAddr;
      mCyc = 0; mDoneAt = 0; mBusy = 0; mLastLdr = 1; mOwnerLdr = 0; mIsWrite = 0; mAddr = '0;
      for (int i = 0; i < 1024; i++) golden[i] = initWord(i);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mBusy = 0; mLastLdr = 1;
            expPipeDone = 0; expLdrDone = 0; expMemEn = 0; expMemWe = 0;
            expMemAddr = '0; expMemWdata = '0; expPipeRdata = '0; expLdrRdata = '0;
         end else begin
            mCyc++;
            pWants = (pipe_rd | pipe_wr) & ~expPipeDone;
            lWants = ldr_req & ~expLdrDone;
            expPipeDone = 0;
            expLdrDone  = 0;
            if (mBusy) begin
               expMemEn = 0;
               if (mCyc == mDoneAt) begin
                  mBusy = 0;
                  expMemWe = 0;
                  if (mOwnerLdr) begin
                     expLdrDone = 1;
                     if (!mIsWrite) expLdrRdata = golden[mAddr];
                  end else begin
                     expPipeDone = 1;
                     if (!mIsWrite) expPipeRdata = golden[mAddr];
                  end
               end
            end else if (pWants | lWants) begin
               mOwnerLdr = (pWants & lWants) ? ~mLastLdr : lWants;
               mLastLdr  = mOwnerLdr;
               if (mOwnerLdr) begin
                  mAddr = ldr_addr; mIsWrite = ldr_we; expMemWdata = ldr_wdata;
               end else begin
                  mAddr = pipe_addr; mIsWrite = pipe_wr & ~pipe_rd; expMemWdata = pipe_wdata;
               end
               if (mIsWrite) golden[mAddr] = expMemWdata;
               expMemAddr = mAddr;
               expMemWe   = mIsWrite;
               expMemEn   = 1;
               mBusy      = 1;
               mDoneAt    = mCyc + LAT;
            end
         end
      end
   end

   // Every-cycle comparison of dut against the model.
   always @(negedge clk) begin
      checkOutput("pipe_rdata", pipe_rdata, expPipeRdata);
      checkOutput("ldr_rdata", ldr_rdata, expLdrRdata);
      checkOutput("pipe_done", {31'd0, pipe_done}, {31'd0, expPipeDone});
      checkOutput("ldr_done", {31'd0, ldr_done}, {31'd0, expLdrDone});
      checkOutput("mem_en", {31'd0, mem_en}, {31'd0, expMemEn});
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, expMemWe});
      checkOutput("mem_addr", {22'd0, mem_addr}, {22'd0, expMemAddr});
      checkOutput("mem_wdata", mem_wdata, expMemWdata);
      checkOutput("pipe_stall", {31'd0, pipe_stall}, {31'd0, (pipe_rd | pipe_wr) & ~expPipeDone});
   end

   // Event log used by the directed scenarios.
   always @(negedge clk) begin
      if (mem_en) begin
         memEnCnt++;
         lastStrobeAddr = mem_addr;
         lastStrobeWe   = mem_we;
      end
      if (pipe_done) begin
         pipeDoneCnt++;
         doneOwner.push_back(0);
         doneTime.push_back(negCnt);
      end
      if (ldr_done) begin
         ldrDoneCnt++;
         doneOwner.push_back(1);
         doneTime.push_back(negCnt);
      end
      if (pipe_stall) stallCnt++;
      negCnt++;
   end

   // One pipeline access. The caller sits just after a rising edge, so the
   // request is sampled at the next edge. lat is the number of cycles after
   // that edge until the done cycle, and stalls counts stalled cycles.
   task automatic applyStimulus(input logic isWrite, input logic [9:0] addr, input logic [31:0] wdata,
                                output int lat, output int stalls);
      int n;
      n = 0; stalls = 0; lat = -1;
      pipe_rd = ~isWrite; pipe_wr = isWrite; pipe_addr = addr; pipe_wdata = wdata;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         n++;
         if (pipe_stall) stalls++;
         if (pipe_done) begin
            lat = n - 1;
            break;
         end
      end
      @(posedge clk); #1;
      pipe_rd = 0; pipe_wr = 0;
   endtask

   task automatic pulseReset();
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      int   lat, st, base, stallBase, doneBase;
      logic got;
      pipe_rd = 0; pipe_wr = 0; pipe_addr = '0; pipe_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      pipeRd1 = 0; pipeWr1 = 0; pipeAddr1 = '0; pipeWdata1 = '0;
      ldrReq1 = 0; ldrWe1 = 0; ldrAddr1 = '0; ldrWdata1 = '0;

      // Reset values of both instances.
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_pipe_rdata", pipe_rdata, 32'h0);
      checkOutput("rst_ldr_rdata", ldr_rdata, 32'h0);
      checkOutput("rst_dones", {30'd0, pipe_done, ldr_done}, 32'h0);
      checkOutput("rst_mem_ctl", {30'd0, mem_en, mem_we}, 32'h0);
      checkOutput("rst_mem_addr", {22'd0, mem_addr}, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      checkOutput("rst_pipe_stall", {31'd0, pipe_stall}, 32'h0);
      checkOutput("rst1_rdata", pipeRdata1 | ldrRdata1 | memWdata1, 32'h0);
      checkOutput("rst1_ctl", {26'd0, pipeDone1, ldrDone1, memEn1, memWe1, pipeStall1, |memAddr1}, 32'h0);
      rst_n = 1;
      @(posedge clk); #1;

      // Single uncontended read from address 3.
      base = memEnCnt;
      applyStimulus(1'b0, 10'd3, 32'h0, lat, st);
      checkOutput("s1_latency", lat, 3);
      checkOutput("s1_stall_cycles", st, 3);
      checkOutput("s1_rdata", pipe_rdata, 32'h8765_4321);
      checkOutput("s1_strobes", memEnCnt - base, 1);
      checkOutput("s1_strobe_addr", {22'd0, lastStrobeAddr}, 32'd3);

      // Write then read back address 29.
      applyStimulus(1'b1, 10'd29, 32'h1111_1111, lat, st);
      checkOutput("s2_wr_latency", lat, 3);
      checkOutput("s2_wr_strobe_we", {31'd0, lastStrobeWe}, 32'd1);
      checkOutput("s2_wr_strobe_addr", {22'd0, lastStrobeAddr}, 32'd29);
      checkOutput("s2_rdata_kept", pipe_rdata, 32'h8765_4321);
      applyStimulus(1'b0, 10'd29, 32'h0, lat, st);
      checkOutput("s2_rd_strobe_we", {31'd0, lastStrobeWe}, 32'd0);
      checkOutput("s2_readback", pipe_rdata, 32'h1111_1111);

      // Contention straight after reset: pipe, ldr, pipe, ldr with no bubble.
      pulseReset();
      doneOwner.delete();
      doneTime.delete();
      pipe_rd = 1; pipe_addr = 10'd7;
      ldr_req = 1; ldr_we = 0; ldr_addr = 10'd12;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         if (doneOwner.size() >= 4) break;
      end
      #1;
      pipe_rd = 0; ldr_req = 0;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("s3_done_count", {31'd0, doneOwner.size() >= 4}, 32'd1);
      if (doneOwner.size() >= 4) begin
         checkOutput("s3_order", {28'd0, doneOwner[0][0], doneOwner[1][0], doneOwner[2][0], doneOwner[3][0]}, 32'b0101);
         checkOutput("s3_gap01", doneTime[1] - doneTime[0], 3);
         checkOutput("s3_gap12", doneTime[2] - doneTime[1], 3);
         checkOutput("s3_gap23", doneTime[3] - doneTime[2], 3);
      end
      checkOutput("s3_pipe_rdata", pipe_rdata, initWord(7));
      checkOutput("s3_ldr_rdata", ldr_rdata, initWord(12));

      // Loader-only writes of A0..A3 to addresses 0..3; the pipeline never stalls.
      stallBase = stallCnt;
      ldr_req = 1; ldr_we = 1;
      for (int k = 0; k < 4; k++) begin
         ldr_addr  = 10'(k);
         ldr_wdata = 32'hA0 + 32'(k);
         base = ldrDoneCnt;
         got  = 0;
         for (int w = 0; w < 20; w++) begin
            @(posedge clk);
            if (ldrDoneCnt != base) begin
               got = 1;
               break;
            end
         end
         checkOutput("s4_write_done", {31'd0, got}, 32'd1);
         #1;
      end
      ldr_req = 0; ldr_we = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) checkOutput("s4_mem_word", envMem[k], 32'hA0 + 32'(k));
      checkOutput("s4_no_stall", stallCnt - stallBase, 0);

      // Reset in the middle of a pipeline read.
      pipe_rd = 1; pipe_addr = 10'd10;
      @(posedge clk); #1;
      checkOutput("s5_strobe_live", {31'd0, mem_en}, 32'd1);
      doneBase = pipeDoneCnt;
      rst_n = 0; pipe_rd = 0;
      #1;
      checkOutput("s5_rdata_zero", pipe_rdata | ldr_rdata, 32'h0);
      checkOutput("s5_ctl_zero", {28'd0, pipe_done, ldr_done, mem_en, mem_we}, 32'h0);
      checkOutput("s5_bus_zero", mem_wdata | {22'd0, mem_addr}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("s5_no_done", pipeDoneCnt - doneBase, 0);
      applyStimulus(1'b0, 10'd10, 32'h0, lat, st);
      checkOutput("s5_after_latency", lat, 3);
      checkOutput("s5_after_rdata", pipe_rdata, initWord(10));

      // MEM_LAT = 1 instance: done in the second cycle after the request edge.
      pipeRd1 = 1; pipeAddr1 = 10'd3;
      lat = -1; st = 0; base = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         base++;
         if (pipeStall1) st++;
         if (pipeDone1) begin
            lat = base - 1;
            break;
         end
      end
      @(posedge clk); #1;
      pipeRd1 = 0;
      checkOutput("s6_latency", lat, 2);
      checkOutput("s6_stall_cycles", st, 2);
      checkOutput("s6_rdata", pipeRdata1, 32'h8765_4321);

      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
